// File: rtl/avg_tx_pkg.sv
// Shared definitions for the averaged-frame USB transmitter.
//   tx_state_e          : transmitter FSM states
//   CRC16_POLY          : USB CRC16 generator polynomial (normal form)
//   CRC16_INIT          : CRC seed loaded at the start of each packet
//   DEFAULT_FRAME_BYTES : 64 data bytes + 2 header bytes
//   reflect16()         : bit-reverses a 16-bit word (LSB-first CRC form)
package avg_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StData  = 2'd1,
        StCrcLo = 2'd2,
        StCrcHi = 2'd3
    } tx_state_e;

    localparam logic [15:0] CRC16_POLY          = 16'h8005;
    localparam logic [15:0] CRC16_INIT          = 16'hFFFF;
    localparam int unsigned DEFAULT_FRAME_BYTES = 66;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_crc16_byte.sv
// Combinational USB CRC16 update for one data byte (reflected, LSB-first).
// Ports:
//   i_crc  [15:0] : current CRC register value
//   i_data [7:0]  : byte being transferred
//   o_crc  [15:0] : CRC after absorbing i_data
module tx_crc16_byte
    import avg_tx_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    // Reflected polynomial lets the shift run right, consuming the byte LSB first.
    localparam logic [15:0] PolyRefl = reflect16(CRC16_POLY);

    logic [15:0] w_acc;

    always_comb begin
        w_acc = i_crc ^ {8'h00, i_data};
        for (int i = 0; i < 8; i++) begin
            if (w_acc[0]) begin
                w_acc = (w_acc >> 1) ^ PolyRefl;
            end else begin
                w_acc = w_acc >> 1;
            end
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/avg_frame_tx.sv
// Serialises one averaged frame into a byte stream for the USB transmit path.
// A frame is captured on frame_load while idle and sent byte 0 first; new
// loads arriving while a frame is held are rejected with a frame_drop pulse.
// Optional feature macro: AVG_TX_CRC_EN appends the inverted USB CRC16
// (low byte, then high byte with tx_last). Without it, tx_last marks the
// final data byte.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   frame_in   : averaged frame, sampled when frame_load is high
//   frame_load : one-cycle load strobe
//   tx_ready   : sink accepts tx_data this cycle
//   tx_data    : byte presented to the sink (0 when idle)
//   tx_valid   : tx_data valid
//   tx_last    : final byte of the packet
//   busy       : frame held or being sent
//   frame_drop : one-cycle pulse after a rejected frame_load
module avg_frame_tx
    import avg_tx_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = DEFAULT_FRAME_BYTES,
    parameter int unsigned FRAME_W     = FRAME_BYTES * 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_load,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    output logic               busy,
    output logic               frame_drop
);

    localparam int unsigned     CntW    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_BYTES - 1);

    tx_state_e                   r_state;
    tx_state_e                   w_state_next;
    logic [CntW-1:0]             r_cnt;
    logic [FRAME_BYTES-1:0][7:0] r_held;
    logic                        r_drop;
    logic                        w_load_ok;
    logic                        w_data_xfer;
    logic                        w_last_data;

    assign w_load_ok   = (r_state == StIdle) && frame_load;
    assign w_data_xfer = (r_state == StData) && tx_ready;
    assign w_last_data = (r_cnt == LastIdx);
    assign frame_drop  = r_drop;

`ifdef AVG_TX_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    tx_crc16_byte u_crc (
        .i_crc  (r_crc),
        .i_data (r_held[r_cnt]),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (w_load_ok) begin
            r_crc <= CRC16_INIT;
        end else if (w_data_xfer) begin
            r_crc <= w_crc_next;
        end
    end
`endif

    // Holding register needs no reset: it is only observed outside StIdle.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_held <= frame_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= frame_load && (r_state != StIdle);
            if (w_load_ok) begin
                r_cnt <= '0;
            end else if (w_data_xfer && !w_last_data) begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        tx_last      = 1'b0;
        busy         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (frame_load) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = r_held[r_cnt];
`ifdef AVG_TX_CRC_EN
                if (tx_ready && w_last_data) begin
                    w_state_next = StCrcLo;
                end
`else
                tx_last = w_last_data;
                if (tx_ready && w_last_data) begin
                    w_state_next = StIdle;
                end
`endif
            end
`ifdef AVG_TX_CRC_EN
            StCrcLo: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = ~r_crc[7:0];
                if (tx_ready) begin
                    w_state_next = StCrcHi;
                end
            end
            StCrcHi: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_last  = 1'b1;
                tx_data  = ~r_crc[15:8];
                if (tx_ready) begin
                    w_state_next = StIdle;
                end
            end
`endif
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_avg_frame_tx.sv
// Self-checking bench for avg_frame_tx: a packet-level model (queue of the
// bytes still owed) is compared against the DUT on every cycle, plus literal
// expectations for the known-answer packets.
module tb_avg_frame_tx;

`ifdef AVG_TX_CRC_EN
    localparam int NB    = 9;
    localparam bit CrcOn = 1'b1;
`else
    localparam int NB    = 4;
    localparam bit CrcOn = 1'b0;
`endif
    localparam int FW     = NB * 8;
    localparam int PktLen = CrcOn ? NB + 2 : NB;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] frame_in;
    logic          frame_load;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          busy;
    logic          frame_drop;

    always #5 clk = ~clk;

    avg_frame_tx #(
        .FRAME_BYTES (NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_load (frame_load),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .busy       (busy),
        .frame_drop (frame_drop)
    );

    int         checks    = 0;
    int         errors    = 0;
    bit         chk_en    = 1'b0;
    int         drop_seen = 0;
    logic       exp_drop  = 1'b0;
    logic [8:0] exp_q[$];   // {last, data} still to be sent
    logic [8:0] cap_q[$];   // {last, data} actually transferred
    logic [8:0] lit_q[$];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // USB CRC16 one bit at a time, LSB of each byte first.
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = b[i] ^ c[0];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    task automatic build_packet(input logic [FW-1:0] f);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < NB; k++) begin
            b = f[8*k +: 8];
            exp_q.push_back({(!CrcOn && k == NB - 1), b});
            c = crc_bits(c, b);
        end
        if (CrcOn) begin
            exp_q.push_back({1'b0, ~c[7:0]});
            exp_q.push_back({1'b1, ~c[15:8]});
        end
    endtask

    // Compare this cycle, then advance the model past the coming edge.
    always @(negedge clk) begin
        logic       mb;
        logic [8:0] hd;
        if (chk_en) begin
            mb = (exp_q.size() != 0);
            hd = mb ? exp_q[0] : 9'h000;
            check1("busy", 32'(busy), 32'(mb));
            check1("tx_valid", 32'(tx_valid), 32'(mb));
            check1("tx_data", 32'(tx_data), 32'(hd[7:0]));
            check1("tx_last", 32'(tx_last), 32'(hd[8]));
            check1("frame_drop", 32'(frame_drop), 32'(exp_drop));
            if (frame_drop === 1'b1) drop_seen++;
            if (tx_valid === 1'b1 && tx_ready) cap_q.push_back({tx_last, tx_data});
            if (rst) begin
                exp_q.delete();
                exp_drop = 1'b0;
            end else begin
                exp_drop = frame_load && mb;
                if (mb && tx_ready) void'(exp_q.pop_front());
                else if (!mb && frame_load) build_packet(frame_in);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [FW-1:0] f);
        frame_in   = f;
        frame_load = 1'b1;
        tick();
        frame_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check1("wait_idle busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < NB; k++) f[8*k +: 8] = 8'($urandom);
        return f;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] f;
        logic [15:0]   c;
        int            d0;
        int            m;

        rst        = 1'b1;
        frame_load = 1'b0;
        tx_ready   = 1'b0;
        frame_in   = '0;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Known-answer packet.
`ifdef AVG_TX_CRC_EN
        for (int k = 0; k < NB; k++) begin
            f[8*k +: 8] = 8'(8'h31 + k);
            lit_q.push_back({1'b0, 8'(8'h31 + k)});
        end
        lit_q.push_back(9'h0C8);
        lit_q.push_back(9'h1B4);
        c = 16'hFFFF;
        for (int k = 0; k < NB; k++) c = crc_bits(c, f[8*k +: 8]);
        check1("model crc of 123456789", 32'(c), 32'h4B37);
`else
        f = 32'hDDCCBBAA;
        lit_q.push_back(9'h0AA);
        lit_q.push_back(9'h0BB);
        lit_q.push_back(9'h0CC);
        lit_q.push_back(9'h1DD);
`endif
        tx_ready = 1'b1;
        cap_q.delete();
        load(f);
        wait_idle(PktLen + 5);
        check1("known packet length", 32'(cap_q.size()), 32'(PktLen));
        for (int i = 0; i < lit_q.size(); i++) begin
            if (i < cap_q.size()) check1($sformatf("known byte %0d", i), 32'(cap_q[i]),
                                         32'(lit_q[i]));
        end

        // Sink stalls every other cycle.
        cap_q.delete();
        load(rand_frame());
        for (int n = 0; n < 4 * PktLen + 10 && busy === 1'b1; n++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        check1("stall busy", 32'(busy), 32'd0);
        check1("stall transfer count", 32'(cap_q.size()), 32'(PktLen));

        // Loads mid-packet and on the final transfer are dropped.
        tx_ready = 1'b1;
        tick();
        d0 = drop_seen;
        m  = NB / 2;
        load(rand_frame());
        repeat (m) tick();
        load(rand_frame());
        repeat (PktLen - 2 - m) tick();
        load(rand_frame());
        wait_idle(PktLen + 5);
        tick();
        tick();
        check1("drop pulses", 32'(drop_seen - d0), 32'd2);

        // Reset mid-packet, then a fresh frame.
        load(rand_frame());
        repeat (m) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(rand_frame());
        wait_idle(PktLen + 5);
        tick();

        // Back-to-back: load in the cycle right after the last transfer.
        d0 = drop_seen;
        load(rand_frame());
        repeat (PktLen - 1) tick();
        tick();
        load(rand_frame());
        check1("b2b busy", 32'(busy), 32'd1);
        wait_idle(PktLen + 5);
        tick();
        check1("b2b drops", 32'(drop_seen - d0), 32'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            frame_load = ($urandom_range(0, 5) == 0);
            tx_ready   = ($urandom_range(0, 3) != 0);
            frame_in   = rand_frame();
            tick();
        end
        rst        = 1'b0;
        frame_load = 1'b0;
        tx_ready   = 1'b1;
        wait_idle(PktLen + 5);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avg_frame_tx.md
AVG_FRAME_TX -- requirements
Module: avg_frame_tx

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 66, giving bytes per averaged frame (64 data + 2 header).
REQ-002 SHALL have parameter FRAME_W, default FRAME_BYTES*8, giving the frame bus width.
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: frame_in  input  FRAME_W  averaged frame from the averager bank.
REQ-007 SHALL have port: frame_load  input  1  one-cycle strobe; frame_in is valid this cycle.
REQ-008 SHALL have port: tx_ready  input  1  USB transmit side accepts a byte this cycle.
REQ-009 SHALL have port: tx_data  output  8  byte presented to USB transmit.
REQ-010 SHALL have port: tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port: tx_last  output  1  final byte of the packet.
REQ-012 SHALL have port: busy  output  1  frame held or in transmission.
REQ-013 SHALL have port: frame_drop  output  1  one-cycle pulse when a frame_load is rejected.

Function
REQ-014 SHALL implement states IDLE, DATA, CRC_LO, CRC_HI.
REQ-015 IDLE with frame_load: SHALL capture frame_in into a holding register, clear the byte counter, initialise CRC to 16'hFFFF, and go to DATA.
REQ-016 frame_load outside IDLE SHALL be ignored, with frame_drop asserted the next cycle; the held frame SHALL be unaffected.
REQ-017 Latency: tx_valid SHALL rise in the cycle after the accepted frame_load, with byte 0 = frame_in[7:0].
REQ-018 Bytes SHALL be sent in ascending order; byte k = held[8k+7:8k].
REQ-019 A byte transfers only when tx_valid and tx_ready are both high.
REQ-020 tx_data, tx_valid and tx_last SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-021 tx_valid SHALL stay high continuously from the first byte through the last byte; no bubbles are inserted.
REQ-022 CRC SHALL be USB CRC16: polynomial 0x8005, reflected, LSB-first, init 0xFFFF, final value inverted.
REQ-023 The CRC SHALL be updated once per transferred data byte.
REQ-024 DATA: on transfer of byte FRAME_BYTES-1, the block SHALL go to CRC_LO (or IDLE, per REQ-033); otherwise the counter increments.
REQ-025 CRC_LO SHALL present inverted CRC[7:0]; CRC_HI SHALL present inverted CRC[15:8] with tx_last=1.
REQ-026 A CRC_HI transfer SHALL return the block to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 In IDLE, tx_valid and tx_last SHALL be 0 and tx_data SHALL be 8'h00.
REQ-029 A frame_load in the same cycle as the final transfer SHALL be dropped (busy still 1), with frame_drop pulsed.
REQ-030 The byte counter width SHALL be $clog2(FRAME_BYTES) and SHALL never wrap past FRAME_BYTES-1.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, counter 0, CRC 16'hFFFF, and tx_data=0, tx_valid=0, tx_last=0, busy=0, frame_drop=0.
REQ-032 Reset mid-packet SHALL abandon the packet; there is no resume, and the next frame_load starts at byte 0.

Configuration
REQ-033 Macro AVG_TX_CRC_EN:
- Defined: CRC_LO and CRC_HI are present; the packet is FRAME_BYTES+2 bytes.
- Undefined: CRC logic and states are omitted, tx_last asserts on data byte FRAME_BYTES-1, and that transfer returns the block to IDLE.

Structure
REQ-034 A shared package avg_tx_pkg SHALL hold the state enum, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF and DEFAULT_FRAME_BYTES=66.
REQ-035 A sub-module tx_crc16_byte SHALL compute the combinational next CRC from the current CRC and one data byte; it is instantiated only under AVG_TX_CRC_EN.

Verification
REQ-036 FRAME_BYTES=9, CRC on: load bytes "123456789" (0x31..0x39), tx_ready=1 -> 0x31..0x39 then 0xC8, 0xB4 on consecutive cycles; tx_last only on 0xB4.
REQ-037 FRAME_BYTES=66, tx_ready toggled 1/0 each cycle -> 68 transfers in order; tx_data stable during every stalled cycle; busy low the cycle after the last transfer.
REQ-038 frame_load pulsed at data byte 10 and again on the final transfer cycle -> frame_drop pulses twice; output packet identical to the first frame.
REQ-039 rst asserted at byte 30 for one cycle, then a new frame loaded -> all outputs 0 the cycle after reset; new packet starts at its byte 0 with a fresh CRC.
REQ-040 Macro undefined, FRAME_BYTES=4, frame 0xDDCCBBAA -> bytes AA, BB, CC, DD with tx_last on DD; no CRC bytes follow.
REQ-041 Back-to-back loads: frame_load one cycle after tx_last transfer -> accepted, tx_valid high the following cycle, no frame_drop.
